// File: rtl/wide_op_sequencer_pkg.sv
// Shared definitions for the wide-op sequencer: byte-ALU opcodes and 16-bit command codes.
// Imported by the sequencer, its bus interface and anything that models the external ALU.
package wide_op_sequencer_pkg;

    typedef enum logic [2:0] {
        kNOP = 3'd0,
        kADD = 3'd1,
        kLSH = 3'd2,
        kRSH = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        CMD_ADD16 = 2'b00,
        CMD_LSH16 = 2'b01,
        CMD_RSH16 = 2'b10,
        CMD_RSVD  = 2'b11
    } wide_cmd_e;

    function automatic alu_op_e cmd_to_alu_op(input wide_cmd_e cmd);
        alu_op_e op;
        case (cmd)
            CMD_ADD16: op = kADD;
            CMD_LSH16: op = kLSH;
            CMD_RSH16: op = kRSH;
            default:   op = kNOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/wide_op_sequencer_if.sv
// Bus bundle for the wide-op sequencer: command/result side plus the byte-ALU drive/return.
// master = requester that also hosts the ALU; slave = the sequencer itself.
interface wide_op_sequencer_if;
    import wide_op_sequencer_pkg::*;

    logic        start;
    wide_cmd_e   cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;

    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    alu_op_e     alu_op;
    logic        alu_sc_in;
    logic [7:0]  alu_out;
    logic        alu_sc_out;

    modport master (
        output start, cmd, a, b,
        input  busy, done, result, carry, zero,
        input  alu_a, alu_b, alu_op, alu_sc_in,
        output alu_out, alu_sc_out
    );

    modport slave (
        input  start, cmd, a, b,
        output busy, done, result, carry, zero,
        output alu_a, alu_b, alu_op, alu_sc_in,
        input  alu_out, alu_sc_out
    );

endinterface

// File: rtl/wide_op_sequencer.sv
// Sequences a 16-bit ADD/LSH/RSH over an external 8-bit ALU in two byte steps.
// Latency: DONE three cycles after the accepting edge (FIRST, SECOND, FIN).
// Backpressure: none; START is ignored while BUSY and only sampled in IDLE.
module wide_op_sequencer
    import wide_op_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    wide_op_sequencer_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FIRST  = 2'd1;
    localparam logic [1:0] SECOND = 2'd2;
    localparam logic [1:0] FIN    = 2'd3;

    logic [1:0]  state;
    wide_cmd_e   cmd_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] result_q;
    logic [15:0] result_nxt;
    logic        carry_q;
    logic        zero_q;

    logic        hi_step;
    logic        to_hi_byte;
    logic        rsvd;
    logic [7:0]  cap_byte;
    logic        cap_carry;

    logic [7:0]  alu_a_d;
    logic [7:0]  alu_b_d;
    alu_op_e     alu_op_d;
    logic        alu_sc_d;

    // ALU drive is idle outside the two byte steps so the ALU sees a quiet bus.
    always_comb begin
        hi_step  = (state == SECOND);
        rsvd     = (cmd_q == CMD_RSVD);
        alu_a_d  = 8'h00;
        alu_b_d  = 8'h00;
        alu_op_d = kNOP;
        alu_sc_d = 1'b0;
        if (state == FIRST || state == SECOND) begin
            alu_op_d = cmd_to_alu_op(cmd_q);
            alu_sc_d = hi_step && !rsvd && carry_q;
            case (cmd_q)
                CMD_ADD16: begin
                    alu_a_d = hi_step ? a_q[15:8] : a_q[7:0];
                    alu_b_d = hi_step ? b_q[15:8] : b_q[7:0];
                end
                CMD_LSH16: alu_a_d = hi_step ? a_q[15:8] : a_q[7:0];
                CMD_RSH16: alu_a_d = hi_step ? a_q[7:0]  : a_q[15:8];
                default:   alu_a_d = 8'h00;
            endcase
        end
    end

    // Right shifts walk from the high byte down, so the byte order flips.
    always_comb begin
        to_hi_byte = (cmd_q == CMD_RSH16) ? !hi_step : hi_step;
        cap_byte   = rsvd ? 8'h00 : bus.alu_out;
        cap_carry  = !rsvd && bus.alu_sc_out;
        result_nxt = result_q;
        if (to_hi_byte) begin
            result_nxt[15:8] = cap_byte;
        end else begin
            result_nxt[7:0] = cap_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cmd_q    <= CMD_ADD16;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= FIRST;
                        cmd_q <= bus.cmd;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                    end
                end
                FIRST: begin
                    state    <= SECOND;
                    result_q <= result_nxt;
                    carry_q  <= cap_carry;
                end
                SECOND: begin
                    state    <= FIN;
                    result_q <= result_nxt;
                    carry_q  <= cap_carry;
                    zero_q   <= (result_nxt == 16'h0000);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.alu_a     = alu_a_d;
    assign bus.alu_b     = alu_b_d;
    assign bus.alu_op    = alu_op_d;
    assign bus.alu_sc_in = alu_sc_d;

endmodule
